// File: rtl/ultrasonic_scheduler_if.sv
// Pin and result bundle between the ultrasonic sequencer and its neighbours:
// the echo/trig sensor pins on one side, and the distance/near-flag consumers on the other.
interface ultrasonic_scheduler_if #(
   parameter int NUM_SENS = 4,
   parameter int IDW      = (NUM_SENS > 1) ? $clog2(NUM_SENS) : 1
);
   logic                en;
   logic [NUM_SENS-1:0] echo;
   logic [NUM_SENS-1:0] trig;
   logic [19:0]         meas_us;
   logic [IDW-1:0]      meas_id;
   logic                meas_valid;
   logic                meas_timeout;
   logic [NUM_SENS-1:0] near;
   logic                busy;

   modport master (
      output en, echo,
      input  trig, meas_us, meas_id, meas_valid, meas_timeout, near, busy
   );

   modport slave (
      input  en, echo,
      output trig, meas_us, meas_id, meas_valid, meas_timeout, near, busy
   );
endinterface

// File: rtl/ultrasonic_scheduler.sv
// Round-robin HC-SR04 sequencer: trig pulse, echo-rise wait, echo width in us,
// tagged publish with near flag, hold-off, then advance to the next sensor.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for en; trig low, busy low
// TRIG      | trig[id] high for TRIG_US microseconds
// WAIT_ECHO | waiting for a fresh 0->1 on echo[id]; WAIT_US guard
// MEASURE   | counting echo high time in us; MAX_US guard
// HOLDOFF   | quiet gap of HOLDOFF_US before moving to the next sensor
module ultrasonic_scheduler #(
   parameter int CLK_HZ     = 50000000,
   parameter int NUM_SENS   = 4,
   parameter int TRIG_US    = 10,
   parameter int WAIT_US    = 30000,
   parameter int MAX_US     = 25000,
   parameter int HOLDOFF_US = 60000,
   parameter int NEAR_US    = 580
) (
   input  logic                   clk,
   input  logic                   rst,
   ultrasonic_scheduler_if.slave  bus
);

   localparam int CPU = CLK_HZ / 1000000;
   localparam int IDW = (NUM_SENS > 1) ? $clog2(NUM_SENS) : 1;
   localparam int SW  = (CPU > 2) ? $clog2(CPU) : 1;
   localparam int UW  = 20;

   localparam logic [SW-1:0]  SUB_LOAD  = SW'(CPU - 1);
   localparam logic [UW-1:0]  TRIG_LAST = UW'(TRIG_US - 1);
   localparam logic [UW-1:0]  WAIT_LAST = UW'(WAIT_US - 1);
   localparam logic [UW-1:0]  MAX_LAST  = UW'(MAX_US - 1);
   localparam logic [UW-1:0]  HOLD_LAST = UW'(HOLDOFF_US - 1);
   localparam logic [UW-1:0]  NEAR_LIM  = UW'(NEAR_US);
   localparam logic [IDW-1:0] ID_LAST   = IDW'(NUM_SENS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_ECHO = 3'd2,
      MEASURE   = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [IDW-1:0]      id;
   logic [NUM_SENS-1:0] echo_m, echo_q;
   logic                echo_s, echo_p;
   logic                echo_rise, echo_fall;

   logic [SW-1:0]       sub_cnt;
   logic [UW-1:0]       us_cnt;
   logic                us_tick;
   logic [UW-1:0]       width_now;

   logic                pub_ok, pub_to, advance;

   logic [NUM_SENS-1:0] trig_q;
   logic [19:0]         meas_us_q;
   logic [IDW-1:0]      meas_id_q;
   logic                meas_valid_q;
   logic                meas_timeout_q;
   logic [NUM_SENS-1:0] near_q;

   // Two-flop synchronizer on every echo pin; both edges see the same delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         echo_m <= '0;
         echo_q <= '0;
         echo_p <= 1'b0;
      end else begin
         echo_m <= bus.echo;
         echo_q <= echo_m;
         echo_p <= echo_s;
      end
   end

   always_comb begin
      echo_s = 1'b0;
      for (int i = 0; i < NUM_SENS; i++) begin
         if (id == IDW'(i)) echo_s = echo_q[i];
      end
   end

   assign echo_rise = echo_s & ~echo_p;
   assign echo_fall = ~echo_s & echo_p;

   // Microsecond timebase: sub_cnt counts down to its terminal count, then us_cnt steps.
   // Both restart on every state change so each state measures from its own entry.
   assign us_tick   = (sub_cnt == '0);
   assign width_now = us_cnt + UW'(us_tick);

   always_ff @(posedge clk) begin
      if (rst) begin
         sub_cnt <= SUB_LOAD;
         us_cnt  <= '0;
      end else if (state_nxt != state || state == IDLE) begin
         sub_cnt <= SUB_LOAD;
         us_cnt  <= '0;
      end else if (us_tick) begin
         sub_cnt <= SUB_LOAD;
         us_cnt  <= us_cnt + 1'b1;
      end else begin
         sub_cnt <= sub_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pub_ok    = 1'b0;
      pub_to    = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.en) state_nxt = TRIG;
         end
         TRIG: begin
            if (us_tick && us_cnt == TRIG_LAST) state_nxt = WAIT_ECHO;
         end
         WAIT_ECHO: begin
            if (echo_rise) begin
               state_nxt = MEASURE;
            end else if (us_tick && us_cnt == WAIT_LAST) begin
               pub_to    = 1'b1;
               state_nxt = HOLDOFF;
            end
         end
         MEASURE: begin
            // A fall on the same cycle the limit is reached still counts as a real width.
            if (echo_fall) begin
               pub_ok    = 1'b1;
               state_nxt = HOLDOFF;
            end else if (us_tick && us_cnt == MAX_LAST) begin
               pub_to    = 1'b1;
               state_nxt = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (us_tick && us_cnt == HOLD_LAST) begin
               advance   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id             <= '0;
         trig_q         <= '0;
         meas_us_q      <= '0;
         meas_id_q      <= '0;
         meas_valid_q   <= 1'b0;
         meas_timeout_q <= 1'b0;
         near_q         <= '0;
      end else begin
         meas_valid_q <= pub_ok | pub_to;

         if (pub_ok) begin
            meas_us_q      <= width_now;
            meas_id_q      <= id;
            meas_timeout_q <= 1'b0;
         end else if (pub_to) begin
            meas_us_q      <= 20'hFFFFF;
            meas_id_q      <= id;
            meas_timeout_q <= 1'b1;
         end

         for (int i = 0; i < NUM_SENS; i++) begin
            if (id == IDW'(i)) begin
               if (pub_ok)      near_q[i] <= (width_now < NEAR_LIM);
               else if (pub_to) near_q[i] <= 1'b0;
            end
         end

         // Registered from next state so the pin is glitch-free and spans TRIG exactly.
         trig_q <= '0;
         for (int i = 0; i < NUM_SENS; i++) begin
            if (state_nxt == TRIG && id == IDW'(i)) trig_q[i] <= 1'b1;
         end

         if (advance) id <= (id == ID_LAST) ? '0 : id + 1'b1;
      end
   end

   assign bus.trig         = trig_q;
   assign bus.meas_us      = meas_us_q;
   assign bus.meas_id      = meas_id_q;
   assign bus.meas_valid   = meas_valid_q;
   assign bus.meas_timeout = meas_timeout_q;
   assign bus.near         = near_q;
   assign bus.busy         = (state != IDLE);

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
- Round-robin measurement sequencer for up to NUM_SENS HC-SR04-style ultrasonic sensors sharing one echo-timing datapath.
- Per slot: issue trig pulse, wait for echo rise (timeout guarded), time echo high width in microseconds, publish result tagged with sensor id, hold off, advance.
- Sits between the sensor pins and the distance/obstacle logic (sens_ult-style near flags, 20-bit distance bus).

Parameters:
- CLK_HZ, 50000000, system clock frequency; CPU = CLK_HZ/1000000 clocks per microsecond (integer, >=2).
- NUM_SENS, 4, number of sensors (1..8); IDW = max(1,$clog2(NUM_SENS)).
- TRIG_US, 10, trig high time in us.
- WAIT_US, 30000, max us from trig fall to echo rise before timeout.
- MAX_US, 25000, max echo high time in us before timeout (must be < 2^20).
- HOLDOFF_US, 60000, idle gap in us after each slot before next trig.
- NEAR_US, 580, echo width (us) strictly below which near[id] sets (~10 cm).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  scheduler enable; sampled only in IDLE.
- echo  in  NUM_SENS  raw echo pins (asynchronous).
- trig  out  NUM_SENS  trigger pins, at most one high.
- meas_us  out  20  last published echo width in us.
- meas_id  out  IDW  sensor index of last published result.
- meas_valid  out  1  one-cycle strobe: meas_us/meas_id/meas_timeout updated this cycle.
- meas_timeout  out  1  qualifies last result as timeout (meas_us = 0xFFFFF).
- near  out  NUM_SENS  per-sensor obstacle flag, updated on each publish for that id.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at clock edge): state IDLE, slot id 0, trig=0, meas_us=0, meas_id=0, meas_valid=0, meas_timeout=0, near=0, busy=0, synchronizers cleared. Reset overrides any state, including mid-MEASURE; no result is published for the aborted slot.
- echo synchronized by 2-FF per bit; echo_s = synchronized echo[id]. 2-cycle latency on both edges, so width is unaffected.
- Microsecond timebase: sub-counter 0..CPU-1 produces us_tick when it wraps; sub-counter and us counter both clear on every state entry.
- States:
  - IDLE: if en=1 -> TRIG next cycle, else stay.
  - TRIG: trig[id]=1 for exactly TRIG_US*CPU cycles -> WAIT_ECHO.
  - WAIT_ECHO: echo_s rising (0 previous cycle, 1 now) -> MEASURE. us counter reaching WAIT_US -> publish timeout -> HOLDOFF.
  - MEASURE: sub-counter restarts at the echo rise, so an echo high for exactly N*CPU clocks yields meas_us = N; partial microseconds truncate. echo_s falling -> publish width -> HOLDOFF. Width reaching MAX_US while still high -> publish timeout -> HOLDOFF.
  - HOLDOFF: wait HOLDOFF_US us; then id <= (id==NUM_SENS-1) ? 0 : id+1 -> IDLE.
- Echo already high on WAIT_ECHO entry is not a rise; the scheduler waits for a fresh 0->1 transition.
- Publish (single cycle):
  - meas_valid=1; meas_id=id.
  - Normal: meas_us=width, meas_timeout=0, near[id] = (width < NUM_US... i.e. width < NEAR_US).
  - Timeout: meas_us=20'hFFFFF, meas_timeout=1, near[id]=0.
  - Other near bits hold; meas_us/meas_id/meas_timeout hold until next publish.
- en deasserted mid-slot: current slot completes through HOLDOFF, then remains in IDLE.
- Echo activity on non-selected sensors is ignored.
- Width arithmetic is 20-bit unsigned; counters never wrap because both timeouts fire first.

Test Plan:
- Sanity, NUM_SENS=1, HOLDOFF_US=100, en=1, echo high 17500 clk (350 us) after trig -> trig high exactly 500 clk; meas_valid single cycle with meas_us=350, meas_id=0, meas_timeout=0, near[0]=0.
- Near detect: echo high 2500 clk (50 us) -> meas_us=50, near[0]=1; next slot echo 10000 clk (200 us) with NEAR_US=100 -> meas_us=200, near[0]=0.
- Round robin, NUM_SENS=4: echo widths 100/200/300/400 us on ids 0..3 -> publishes in order id 0,1,2,3,0 with matching meas_us; trig never overlaps between sensors.
- Timeouts, WAIT_US=200: echo never rises -> meas_timeout=1, meas_us=0xFFFFF after 200 us post trig fall. MAX_US=300 with echo stuck high -> timeout at 300 us of width.
- Truncation: echo high 17549 clk -> meas_us=350; echo high at WAIT_ECHO entry -> ignored until low then rising.
- Reset mid-MEASURE: assert rst for 1 cycle -> next cycle all outputs at reset values, id=0, no meas_valid; en=0 holds IDLE with busy=0.
